dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port DataMemory (1024×32, combinational read, write on posedge) between the CPU data port (requester 0) and a DMA/debug loader port (requester 1). It grants one access per cycle with round-robin priority and optional bounded burst locking. It drives the memory port and returns a registered response one cycle later. It sits between the CPU core's `data_addr/data_wen/data_write/data_read` signals and the DataMemory instance.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/rr_lock_arb2.sv | 77 +++++++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
package dmem_arb_pkg;

    // Requester identities: the CPU data port and the DMA/debug loader port.
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    localparam int DEF_MEM_DEPTH = 1024;
    localparam int BURST_W       = 4;

    // The requester that is not 'id'.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_CPU) ? REQ_DMA : REQ_CPU;
    endfunction

    // Burst counter increment that sticks at the configured ceiling.
    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] cnt,
                                                   input logic [BURST_W-1:0] max_val);
        return (cnt >= max_val) ? max_val : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/rr_lock_arb2.sv
// Two-way round-robin selector with optional lock held for a bounded burst.
module rr_lock_arb2
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       gnt_any
);

    localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

    req_id_e            last_q, last_d;
    logic               owner_valid_q, owner_valid_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    req_id_e            sel_id;

    // Pick the winner this cycle; an idle cycle reports requester 0 so the memory port shows its values.
    always_comb begin
        sel_id  = REQ_CPU;
        gnt_any = 1'b0;
        if (!rst) begin
            unique case (req)
                2'b01: sel_id = REQ_CPU;
                2'b10: sel_id = REQ_DMA;
                2'b11: begin
                    if (owner_valid_q && (burst_cnt_q < MAX_CNT)) begin
                        sel_id = last_q;
                    end else begin
                        sel_id = other_req(last_q);
                    end
                end
                default: sel_id = REQ_CPU;
            endcase
            gnt_any = |req;
        end
        sel = sel_id;
        gnt = gnt_any ? ((sel_id == REQ_DMA) ? 2'b10 : 2'b01) : 2'b00;
    end

    // Next-state for the rotation pointer, lock ownership and burst length.
    always_comb begin
        last_d        = last_q;
        owner_valid_d = 1'b0;
        burst_cnt_d   = '0;
        if (gnt_any) begin
            last_d = sel_id;
            if (lock[sel_id]) begin
                owner_valid_d = 1'b1;
                if (owner_valid_q && (sel_id == last_q)) begin
                    burst_cnt_d = sat_inc(burst_cnt_q, MAX_CNT);
                end else begin
                    burst_cnt_d = BURST_W'(1);
                end
            end
        end
    end

    // Arbiter state registers; reset leaves the DMA as last so the CPU wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q        <= REQ_DMA;
            owner_valid_q <= 1'b0;
            burst_cnt_q   <= '0;
        end else begin
            last_q        <= last_d;
            owner_valid_q <= owner_valid_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataMemory between the CPU and DMA ports with registered responses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        lock,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [1:0]        err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              sel;
    logic              gnt_any;
    logic              sel_we;
    logic              in_range;
    logic [DATA_W-1:0] resp_data;

    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    rr_lock_arb2 #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .gnt    (gnt),
        .sel    (sel),
        .gnt_any(gnt_any)
    );

    // Steer the winner onto the memory port; out-of-range writes are suppressed here.
    always_comb begin
        mem_addr  = (sel == REQ_DMA) ? addr1 : addr0;
        mem_wdata = (sel == REQ_DMA) ? wdata1 : wdata0;
        sel_we    = we[sel];
        in_range  = {1'b0, mem_addr} < (ADDR_W + 1)'(MEM_DEPTH);
        mem_wen   = gnt_any & sel_we & in_range;
        resp_data = (!sel_we && in_range) ? mem_rdata : '0;
    end

    // Build the response for the granted port; the other port keeps its last data and error.
    always_comb begin
        rvalid_d = gnt;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (gnt[0]) begin
            err_d[0] = ~in_range;
            rdata0_d = resp_data;
        end
        if (gnt[1]) begin
            err_d[1] = ~in_range;
            rdata1_d = resp_data;
        end
    end

    // Response registers, cleared on reset so a pending response is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural arbitration and memory model.
module tb_dmem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 1024;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req, we, lock;
    logic [31:0]       addr0, addr1, wdata0, wdata1;
    logic [1:0]        gnt, rvalid, err;
    logic [31:0]       rdata0, rdata1;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic              mem_wen;

    // Environment DataMemory: combinational read, write on the rising edge.
    logic [31:0] mem_array [0:1023];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } resp_t;

    resp_t       exp_q0[$];
    resp_t       exp_q1[$];

    logic [31:0] model_mem [0:1023];
    bit          model_written [0:1023];
    int          m_last;
    int          m_streak;
    logic [31:0] hold_rdata [2];
    bit          hold_known [2];

    int          n_compared = 0;
    int          n_mismatch = 0;
    logic [1:0]  seen_gnt;
    int          wait0 = 0;
    int          max_wait0 = 0;
    int          dma_run;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .rvalid(rvalid), .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_array[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_wen) mem_array[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flushModel();
        exp_q0.delete();
        exp_q1.delete();
        m_last        = 1;
        m_streak      = 0;
        hold_rdata[0] = '0;
        hold_rdata[1] = '0;
        hold_known[0] = 1'b1;
        hold_known[1] = 1'b1;
    endtask

    // One cycle: drive at negedge+1, check the combinational grant at negedge+4, predict the response.
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        int          g;
        logic [1:0]  exp_gnt;
        logic [31:0] ga, gd;
        logic        gw, exp_wen, in_rng;
        resp_t       e;
        #1;
        req = r; we = w; lock = l;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        #3;
        g = -1;
        if (!rst) begin
            if (r == 2'b01)      g = 0;
            else if (r == 2'b10) g = 1;
            else if (r == 2'b11) g = (m_streak > 0 && m_streak < MAX_BURST) ? m_last : 1 - m_last;
        end
        exp_gnt = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        ga      = (g == 1) ? a1 : a0;
        gd      = (g == 1) ? d1 : d0;
        gw      = (g >= 0) ? w[g] : 1'b0;
        in_rng  = ga < MEM_DEPTH;
        exp_wen = (g >= 0) && gw && in_rng;
        seen_gnt = gnt;
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("mem_wen", 32'(mem_wen), 32'(exp_wen));
        checkOutput("mem_addr", mem_addr, ga);
        checkOutput("mem_wdata", mem_wdata, gd);
        if (req[0] && !gnt[0]) wait0++;
        else wait0 = 0;
        if (wait0 > max_wait0) max_wait0 = wait0;
        if (g >= 0) begin
            e.err = !in_rng;
            if (gw || !in_rng) begin
                e.rdata    = '0;
                e.chk_data = 1'b1;
            end else begin
                e.rdata    = model_mem[ga[9:0]];
                e.chk_data = model_written[ga[9:0]];
            end
            if (g == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            if (exp_wen) begin
                model_mem[ga[9:0]]     = gd;
                model_written[ga[9:0]] = 1'b1;
            end
            if (l[g]) m_streak = (m_streak > 0 && g == m_last) ?
                                 ((m_streak + 1 > MAX_BURST) ? MAX_BURST : m_streak + 1) : 1;
            else      m_streak = 0;
            m_last = g;
        end else begin
            m_streak = 0;
            if (rst) m_last = 1;
        end
        @(negedge clk);
    endtask

    // Monitor side of the scoreboard for one port.
    task automatic checkPort(input int i);
        resp_t       e;
        logic        v;
        logic [31:0] rd;
        int          sz;
        v  = rvalid[i];
        rd = (i == 0) ? rdata0 : rdata1;
        sz = (i == 0) ? exp_q0.size() : exp_q1.size();
        checkOutput($sformatf("rvalid%0d", i), 32'(v), 32'(sz > 0));
        if (sz > 0) begin
            if (i == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            if (e.chk_data) checkOutput($sformatf("rdata%0d", i), rd, e.rdata);
            checkOutput($sformatf("err%0d", i), 32'(err[i]), 32'(e.err));
            hold_rdata[i] = e.rdata;
            hold_known[i] = e.chk_data;
        end else if (hold_known[i]) begin
            checkOutput($sformatf("rdata%0d_hold", i), rd, hold_rdata[i]);
        end
    endtask

    // Monitor: compares presented responses against the queued expectations every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            checkPort(0);
            checkPort(1);
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [1:0]  r, w, l;
        logic [31:0] a [2];
        logic [31:0] d [2];
        bit          pend [2];

        for (int k = 0; k < 1024; k++) model_written[k] = 1'b0;
        rst = 1'b1;
        req = 2'b11; we = 2'b00; lock = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        flushModel();
        @(negedge clk);
        $display("[TB] reset with both requesting");
        repeat (2) applyStimulus(2'b11, 2'b00, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0);
        rst = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0);
        checkOutput("first_contest_cpu", 32'(seen_gnt), 32'h1);
        applyStimulus(2'b11, 2'b00, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0);
        checkOutput("second_contest_dma", 32'(seen_gnt), 32'h2);

        $display("[TB] CPU write then read");
        applyStimulus(2'b01, 2'b01, 2'b00, 32'd5, 32'd0, 32'hDEADBEEF, 32'd0);
        applyStimulus(2'b01, 2'b00, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0);
        applyStimulus(2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);

        $display("[TB] DMA locked burst");
        applyStimulus(2'b10, 2'b00, 2'b10, 32'd7, 32'd5, 32'd0, 32'd0);
        dma_run = seen_gnt[1] ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, 2'b00, 2'b10, 32'd7, 32'd5, 32'd0, 32'd0);
            if (seen_gnt[1] && dma_run == k + 1) dma_run++;
        end
        checkOutput("burst_len", 32'(dma_run), 32'd4);
        checkOutput("cpu_after_burst", 32'(seen_gnt), 32'h1);

        $display("[TB] out-of-range DMA write");
        applyStimulus(2'b01, 2'b01, 2'b00, 32'd0, 32'd0, 32'h12345678, 32'd0);
        applyStimulus(2'b10, 2'b10, 2'b00, 32'd0, 32'd1024, 32'd0, 32'h1);
        applyStimulus(2'b10, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        applyStimulus(2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);

        $display("[TB] reset during locked burst");
        applyStimulus(2'b10, 2'b00, 2'b10, 32'd3, 32'd20, 32'd0, 32'd0);
        #1;
        req = 2'b10; lock = 2'b10; we = 2'b00; addr1 = 32'd21;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_mem_wen", 32'(mem_wen), 32'h0);
        checkOutput("rst_rdata1", rdata1, 32'h0);
        flushModel();
        @(negedge clk);
        applyStimulus(2'b11, 2'b01, 2'b00, 32'd9, 32'd21, 32'hA5A5A5A5, 32'd0);
        rst = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b10, 32'd9, 32'd21, 32'd0, 32'd0);
        checkOutput("post_reset_cpu", 32'(seen_gnt), 32'h1);

        $display("[TB] random traffic");
        pend[0] = 1'b0; pend[1] = 1'b0;
        r = '0; w = '0;
        a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    r[i] = $urandom_range(0, 99) < 60;
                    w[i] = $urandom_range(0, 99) < 40;
                    a[i] = ($urandom_range(0, 99) < 8) ? 32'(1024 + $urandom_range(0, 100))
                                                        : 32'($urandom_range(0, 15));
                    d[i] = $urandom;
                end
                l[i] = $urandom_range(0, 99) < 30;
            end
            applyStimulus(r, w, l, a[0], a[1], d[0], d[1]);
            pend[0] = r[0] && !seen_gnt[0];
            pend[1] = r[1] && !seen_gnt[1];
        end
        applyStimulus(2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        applyStimulus(2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        checkOutput("cpu_max_wait_bounded", 32'(max_wait0 <= MAX_BURST), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
